stopwatch_time_counter: RTL and testbench
=========================================

Name: stopwatch_time_counter

Overview:
Downstream consumer of the KEY0 run/stop mode toggle. Divides the 50 MHz board clock into 10 ms ticks and counts elapsed time as packed BCD MM:SS.CC, from 00:00.00 to 59:59.99, advancing only while run is high. It also provides a lap freeze, which holds the displayed value while counting continues, and a clear input. The output feeds the 7-segment decode stage.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz
TICK_HZ, 100, count resolution in Hz (centiseconds)
DIV, CLK_HZ/TICK_HZ, prescaler modulus; must be >= 2; the bench overrides it to 4

Ports:
clk  in  1  board clock (CLOCK_50)
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = counting, 0 = paused (mode output of the KEY0 toggle)
clear_pulse  in  1  one-cycle pulse; zero the time and cancel lap freeze (edge-detected KEY1)
lap_pulse  in  1  one-cycle pulse; toggle display freeze (edge-detected KEY2)
time_bcd  out  24  displayed time {m_tens,m_ones,s_tens,s_ones,cs_tens,cs_ones}, 4 bits each
frozen  out  1  1 while the display is lap-frozen
wrap  out  1  one-cycle pulse when the live count rolls 59:59.99 -> 00:00.00

Behaviour:
- Reset (async, rst_n=0):
  - prescaler=0, all live digits=0, snapshot=0, frozen=0, wrap=0.
  - Therefore time_bcd=24'h000000.
  - Release is synchronous to clk in the system; the block itself needs no synchronizer.
- Prescaler:
  - Counts 0..DIV-1 only while run=1.
  - Holds its value while run=0, so a pause does not lose the partial tick.
  - tick = run && (prescaler==DIV-1); the prescaler wraps to 0 on the same edge.
  - With run held from prescaler=0, the first tick edge is the DIV-th rising edge.
- Digit cascade on tick, all registered at the same edge:
  - cs_ones 0..9, then cs_tens 0..9, s_ones 0..9, s_tens 0..5, m_ones 0..9, m_tens 0..5.
  - Each digit increments when all lower digits are at their maximum; a digit at max with carry-in goes to 0.
  - Digits never leave their legal range.
- Wrap:
  - A tick with live=59:59.99 makes live=00:00.00.
  - wrap is registered high for exactly the following cycle.
  - Counting continues; there is no stop at max.
- Clear:
  - clear_pulse=1 at an edge forces prescaler=0, live=0, snapshot=0, frozen=0.
  - Clear has priority over a tick, a lap pulse and a wrap in the same cycle; wrap stays 0.
  - run is not affected: if run=1 the count restarts from 0.
- Lap freeze (two states):
  - LIVE: a lap_pulse latches snapshot <= live (the register value before this edge) and enters FROZEN.
  - FROZEN: a lap_pulse returns to LIVE; the display resumes the current live count in the next cycle.
  - Lap is independent of run and works while paused.
- Output:
  - time_bcd = frozen ? snapshot : live, as a combinational mux of registers.
  - Visible latency: one edge after a tick or lap.
- Inputs:
  - Wider-than-one-cycle pulses on clear/lap are treated as repeated events; upstream guarantees single-cycle pulses.
  - run toggling mid-period only gates the prescaler.

Decomposition:
- Package stopwatch_pkg holds:
  - bcd_t (4-bit digit type)
  - digit maxima CS_ONES_MAX=9, CS_TENS_MAX=9, S_ONES_MAX=9, S_TENS_MAX=5, M_ONES_MAX=9, M_TENS_MAX=5
  - the time_bcd field offsets
- One natural sub-module, bcd_digit_counter:
  - Parameter MAX.
  - Ports clk, rst_n, clr, inc, q[3:0], at_max.
  - Six instances are chained, with inc = tick && all lower at_max.
- The top level holds the prescaler, the wrap register, the freeze FSM and the output mux.

Test Plan:
- Reset, then run=1 for 40 cycles (DIV=4) -> time_bcd=24'h000010. Then run=0 for 20 cycles -> time_bcd stays 24'h000010.
- Pause mid-period: run=1 for 6 cycles, run=0 for 10, run=1 for 2 -> tick on the 8th running edge; time_bcd=24'h000002 and no lost or extra tick.
- Lap: count to 24'h000005, pulse lap_pulse, run 40 more cycles -> time_bcd=24'h000005 and frozen=1. Pulse lap_pulse again -> next cycle time_bcd=24'h000015 and frozen=0.
- Clear and tick in the same cycle while frozen, live=24'h000123 -> next cycle time_bcd=24'h000000, frozen=0, wrap=0, prescaler=0.
- Rollover: run to 24'h595999 (359999 ticks, DIV=4), then one more tick -> time_bcd=24'h000000 and wrap=1 for exactly one cycle. Also check 24'h000099 -> 24'h000100 and 24'h005999 -> 24'h010000 carries.
- Async reset mid-count: assert rst_n=0 between clock edges at live=24'h001234 while frozen -> outputs go to 0 and frozen=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared digit type, digit limits and field layout of the MM:SS.CC time word
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        LAP_LIVE   = 1'b0,
        LAP_FROZEN = 1'b1
    } lap_state_e;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;

    localparam bcd_t CS_ONES_MAX = 4'd9;
    localparam bcd_t CS_TENS_MAX = 4'd9;
    localparam bcd_t S_ONES_MAX  = 4'd9;
    localparam bcd_t S_TENS_MAX  = 4'd5;
    localparam bcd_t M_ONES_MAX  = 4'd9;
    localparam bcd_t M_TENS_MAX  = 4'd5;

    localparam int CS_ONES_LSB = 0;
    localparam int CS_TENS_LSB = 4;
    localparam int S_ONES_LSB  = 8;
    localparam int S_TENS_LSB  = 12;
    localparam int M_ONES_LSB  = 16;
    localparam int M_TENS_LSB  = 20;

    // Digit index 0 is centisecond ones, 5 is minute tens.
    function automatic bcd_t digit_max(input int idx);
        return idx == 0 ? CS_ONES_MAX :
               idx == 1 ? CS_TENS_MAX :
               idx == 2 ? S_ONES_MAX  :
               idx == 3 ? S_TENS_MAX  :
               idx == 4 ? M_ONES_MAX  : M_TENS_MAX;
    endfunction

    function automatic int digit_lsb(input int idx);
        return idx == 0 ? CS_ONES_LSB :
               idx == 1 ? CS_TENS_LSB :
               idx == 2 ? S_ONES_LSB  :
               idx == 3 ? S_TENS_LSB  :
               idx == 4 ? M_ONES_LSB  : M_TENS_LSB;
    endfunction

endpackage

// File: rtl/stopwatch_time_counter_digit.sv
// bcd_digit_counter: one BCD digit that rolls over at MAX; at_max feeds the carry chain
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output bcd_t q,
    output logic at_max
);

    bcd_t q_q, q_d;

    assign at_max = (q_q == MAX);
    assign q      = q_q;

    // clear wins over increment; an increment at MAX wraps to zero
    always_comb q_d = clr ? '0 : inc ? (at_max ? '0 : q_q + 4'd1) : q_q;

    // digit register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;

endmodule

// File: rtl/stopwatch_time_counter.sv
// stopwatch_time_counter: 10 ms prescaler, BCD MM:SS.CC cascade, lap freeze and rollover flag
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter int DIV     = CLK_HZ / TICK_HZ
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        clear_pulse,
    input  logic        lap_pulse,
    output logic [23:0] time_bcd,
    output logic        frozen,
    output logic        wrap
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0]         presc_q, presc_d;
    logic                  tick;
    logic                  wrap_q, wrap_d;
    logic [NUM_DIGITS:0]   chain;
    logic [NUM_DIGITS-1:0] at_max;
    logic [23:0]           live;
    logic [23:0]           snap_q, snap_d;
    lap_state_e            state_q, state_d;

    assign tick     = run && (presc_q == PW'(DIV - 1));
    assign chain[0] = tick;

    // chain[i] is the increment for digit i: a tick with every lower digit at its maximum
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit_counter #(.MAX(digit_max(i))) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clear_pulse),
            .inc    (chain[i]),
            .q      (live[digit_lsb(i) +: DIGIT_W]),
            .at_max (at_max[i])
        );
        assign chain[i+1] = chain[i] & at_max[i];
    end

    // prescaler only advances while running, so a pause keeps the partial tick;
    // a carry out of the top digit is the 59:59.99 rollover, suppressed by clear
    always_comb begin
        presc_d = clear_pulse ? '0 : !run ? presc_q : tick ? '0 : presc_q + PW'(1);
        wrap_d  = chain[NUM_DIGITS] && !clear_pulse;
    end

    // lap freeze: entering FROZEN captures the pre-edge live value; clear forces LIVE
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        if (clear_pulse) begin
            state_d = LAP_LIVE;
            snap_d  = '0;
        end else if (lap_pulse) begin
            state_d = (state_q == LAP_LIVE) ? LAP_FROZEN : LAP_LIVE;
            snap_d  = (state_q == LAP_LIVE) ? live : snap_q;
        end
    end

    // prescaler, rollover flag, freeze state and snapshot registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            presc_q <= '0;
            wrap_q  <= 1'b0;
            state_q <= LAP_LIVE;
            snap_q  <= '0;
        end else begin
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
            state_q <= state_d;
            snap_q  <= snap_d;
        end

    assign frozen   = (state_q == LAP_FROZEN);
    assign wrap     = wrap_q;
    assign time_bcd = frozen ? snap_q : live;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// tb_stopwatch_time_counter: vector table, corner sequences and randomized run against a centisecond model
module tb_stopwatch_time_counter;

    localparam int DIV    = 4;
    localparam int MAX_CS = 360000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        clear_pulse;
    logic        lap_pulse;
    logic [23:0] time_bcd;
    logic        frozen;
    logic        wrap;

    int n_checks = 0;
    int n_errors = 0;

    int m_presc, m_live, m_snap;
    bit m_frz, m_wrap;

    logic [23:0] pre_bcd;

    stopwatch_time_counter #(.DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .clear_pulse (clear_pulse),
        .lap_pulse   (lap_pulse),
        .time_bcd    (time_bcd),
        .frozen      (frozen),
        .wrap        (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        r;
        logic        c;
        logic        l;
        int          n;
        logic [23:0] t;
        logic        f;
        logic        w;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [23:0] to_bcd(input int cs);
        int mm = cs / 6000;
        int ss = (cs / 100) % 60;
        int cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic void model_reset();
        m_presc = 0; m_live = 0; m_snap = 0; m_frz = 0; m_wrap = 0;
    endfunction

    function automatic void model_step(input bit r, input bit c, input bit l);
        bit tick = r && (m_presc == DIV - 1);
        int old  = m_live;
        if (c) begin
            model_reset();
        end else begin
            if (r) m_presc = tick ? 0 : m_presc + 1;
            m_wrap = tick && (old == MAX_CS - 1);
            if (tick) m_live = (old + 1) % MAX_CS;
            if (l) begin
                if (!m_frz) m_snap = old;
                m_frz = !m_frz;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_time"}, {8'h0, time_bcd}, {8'h0, m_frz ? to_bcd(m_snap) : to_bcd(m_live)});
        chk({tag, "_frozen"}, {31'h0, frozen}, {31'h0, m_frz});
        chk({tag, "_wrap"}, {31'h0, wrap}, {31'h0, m_wrap});
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input int n);
        for (int k = 0; k < n; k++) begin
            run = r; clear_pulse = c; lap_pulse = l;
            @(posedge clk);
            model_step(r, c, l);
            #1;
        end
        clear_pulse = 1'b0;
        lap_pulse   = 1'b0;
    endtask

    // Loads the live digits directly so the far end of the range is reachable quickly.
    task automatic preload(input int cs);
        pre_bcd = to_bcd(cs);
        force dut.g_dig[0].u_digit.q_q = pre_bcd[3:0];
        force dut.g_dig[1].u_digit.q_q = pre_bcd[7:4];
        force dut.g_dig[2].u_digit.q_q = pre_bcd[11:8];
        force dut.g_dig[3].u_digit.q_q = pre_bcd[15:12];
        force dut.g_dig[4].u_digit.q_q = pre_bcd[19:16];
        force dut.g_dig[5].u_digit.q_q = pre_bcd[23:20];
        drive(1'b0, 1'b0, 1'b0, 1);
        release dut.g_dig[0].u_digit.q_q;
        release dut.g_dig[1].u_digit.q_q;
        release dut.g_dig[2].u_digit.q_q;
        release dut.g_dig[3].u_digit.q_q;
        release dut.g_dig[4].u_digit.q_q;
        release dut.g_dig[5].u_digit.q_q;
        m_live = cs;
    endtask

    task automatic carry_seq(input string name, input int start, input logic [23:0] pre,
                             input logic [23:0] post, input logic w);
        drive(1'b0, 1'b1, 1'b0, 1);
        preload(start);
        chk({name, "_pre"}, {8'h0, time_bcd}, {8'h0, pre});
        drive(1'b1, 1'b0, 1'b0, DIV - 1);
        chk({name, "_hold"}, {8'h0, time_bcd}, {8'h0, pre});
        drive(1'b1, 1'b0, 1'b0, 1);
        chk({name, "_post"}, {8'h0, time_bcd}, {8'h0, post});
        chk({name, "_wrap"}, {31'h0, wrap}, {31'h0, w});
        drive(1'b0, 1'b0, 1'b0, 1);
        chk({name, "_wrap_end"}, {31'h0, wrap}, 32'h0);
        chk({name, "_after"}, {8'h0, time_bcd}, {8'h0, post});
    endtask

    initial begin
        vecs = '{
            '{"run40",    1'b1, 1'b0, 1'b0,  40, 24'h000010, 1'b0, 1'b0},
            '{"pause20",  1'b0, 1'b0, 1'b0,  20, 24'h000010, 1'b0, 1'b0},
            '{"clr",      1'b0, 1'b1, 1'b0,   1, 24'h000000, 1'b0, 1'b0},
            '{"run6",     1'b1, 1'b0, 1'b0,   6, 24'h000001, 1'b0, 1'b0},
            '{"stop10",   1'b0, 1'b0, 1'b0,  10, 24'h000001, 1'b0, 1'b0},
            '{"run7th",   1'b1, 1'b0, 1'b0,   1, 24'h000001, 1'b0, 1'b0},
            '{"run8th",   1'b1, 1'b0, 1'b0,   1, 24'h000002, 1'b0, 1'b0},
            '{"run12",    1'b1, 1'b0, 1'b0,  12, 24'h000005, 1'b0, 1'b0},
            '{"lap_on",   1'b1, 1'b0, 1'b1,   1, 24'h000005, 1'b1, 1'b0},
            '{"run40f",   1'b1, 1'b0, 1'b0,  40, 24'h000005, 1'b1, 1'b0},
            '{"lap_off",  1'b0, 1'b0, 1'b1,   1, 24'h000015, 1'b0, 1'b0},
            '{"lap_on2",  1'b0, 1'b0, 1'b1,   1, 24'h000015, 1'b1, 1'b0},
            '{"run434f",  1'b1, 1'b0, 1'b0, 434, 24'h000015, 1'b1, 1'b0},
            '{"clr_tick", 1'b1, 1'b1, 1'b0,   1, 24'h000000, 1'b0, 1'b0},
            '{"run3",     1'b1, 1'b0, 1'b0,   3, 24'h000000, 1'b0, 1'b0},
            '{"run4th",   1'b1, 1'b0, 1'b0,   1, 24'h000001, 1'b0, 1'b0}
        };

        rst_n = 1'b0; run = 1'b0; clear_pulse = 1'b0; lap_pulse = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_time", {8'h0, time_bcd}, 32'h0);
        chk("reset_frozen", {31'h0, frozen}, 32'h0);
        chk("reset_wrap", {31'h0, wrap}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].r, vecs[i].c, vecs[i].l, vecs[i].n);
            chk({vecs[i].name, "_time"}, {8'h0, time_bcd}, {8'h0, vecs[i].t});
            chk({vecs[i].name, "_frozen"}, {31'h0, frozen}, {31'h0, vecs[i].f});
            chk({vecs[i].name, "_wrap"}, {31'h0, wrap}, {31'h0, vecs[i].w});
            if (vecs[i].c) chk({vecs[i].name, "_presc"}, 32'(dut.presc_q), 32'h0);
        end

        carry_seq("carry_cs", 99, 24'h000099, 24'h000100, 1'b0);
        carry_seq("carry_min", 5999, 24'h005999, 24'h010000, 1'b0);
        carry_seq("rollover", MAX_CS - 1, 24'h595999, 24'h000000, 1'b1);

        drive(1'b0, 1'b1, 1'b0, 1);
        preload(1234);
        drive(1'b0, 1'b0, 1'b1, 1);
        chk("pre_rst_time", {8'h0, time_bcd}, 32'h001234);
        chk("pre_rst_frozen", {31'h0, frozen}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_time", {8'h0, time_bcd}, 32'h0);
        chk("async_rst_frozen", {31'h0, frozen}, 32'h0);
        chk("async_rst_wrap", {31'h0, wrap}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                  $urandom_range(0, 15) == 0, 1);
            chk_model("rnd");
        end

        drive(1'b0, 1'b1, 1'b0, 1);
        preload(MAX_CS - 50);
        chk_model("rnd_top_load");
        for (int k = 0; k < 1000; k++) begin
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0,
                  $urandom_range(0, 31) == 0, 1);
            chk_model("rnd_top");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
